// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared states, SPI core control-word layout and register-select constants.
package spi_arb_pkg;
  typedef enum logic [3:0] {IDLE, LOAD, START, POLL, POLL_WAIT, UNLOAD, ABORT, DONE, RELEASE} state_e;
  localparam int CTRL_SEND = 0;
  localparam int CTRL_ALL_ONES = 1;
  localparam int CTRL_ALL_ZEROS = 2;
  localparam int CTRL_TX_LSB = 4;
  localparam int CTRL_RX_LSB = 16;
  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_DATA = 1'b1;
  function automatic logic [31:0] make_ctrl(input logic [9:0] len);
    logic [31:0] c;
    c = '0;
    c[CTRL_SEND] = 1'b1;
    c[CTRL_ALL_ONES] = 1'b0;
    c[CTRL_ALL_ZEROS] = 1'b0;
    c[CTRL_TX_LSB +: 9] = 9'(len - 10'd1);
    c[CTRL_RX_LSB +: 10] = len - 10'd1;
    return c;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer.
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of the SPI core register port between byte-stream requesters.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DEPTH = 16,
  parameter int LEN_W = $clog2(DEPTH) + 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*LEN_W-1:0] len_i,
  input  logic [N_REQ*8-1:0]     tx_byte_i,
  input  logic [N_REQ-1:0]       tx_valid_i,
  output logic [N_REQ-1:0]       tx_ready_o,
  output logic [7:0]             rx_byte_o,
  output logic [N_REQ-1:0]       rx_valid_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [N_REQ-1:0]       err_o,
  output logic                   busy_o,
  output logic                   wr_o,
  output logic                   reg_sel_o,
  output logic [31:0]            addr_o,
  output logic [31:0]            entrada_o,
  input  logic [31:0]            salida_i
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);
  state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, gnt_idx;
  logic [LEN_W-1:0] len_q, len_d, k_q, k_d, req_len, sat_len;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [N_REQ-1:0] owner_oh, unused_gnt;
  logic gnt_any, timed_out;
  logic [23:0] unused_salida;
  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req_i(req_i),
    .ptr_i(rr_q),
    .gnt_o(unused_gnt),
    .idx_o(gnt_idx),
    .any_o(gnt_any)
  );
  assign req_len = len_i[gnt_idx*LEN_W +: LEN_W];
  assign sat_len = req_len > MAX_LEN ? MAX_LEN : req_len;
  assign owner_oh = N_REQ'(1) << owner_q;
  assign timed_out = cnt_q == CW'(TIMEOUT - 1);
  assign busy_o = state_q != IDLE && state_q != RELEASE;
  assign addr_o = addr_d;
  assign unused_salida = salida_i[31:8];
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    len_d = len_q;
    k_d = k_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    tx_ready_o = '0;
    rx_valid_o = '0;
    rx_byte_o = '0;
    done_o = '0;
    err_o = '0;
    wr_o = 1'b0;
    reg_sel_o = REG_CTRL;
    entrada_o = '0;
    case (state_q)
      IDLE: if (gnt_any) begin
        owner_d = gnt_idx;
        len_d = sat_len;
        k_d = '0;
        state_d = sat_len == '0 ? DONE : LOAD;
      end
      LOAD: begin
        tx_ready_o = owner_oh;
        if (tx_valid_i[owner_q]) begin
          wr_o = 1'b1;
          reg_sel_o = REG_DATA;
          addr_d = 32'(k_q);
          entrada_o = {24'b0, tx_byte_i[owner_q*8 +: 8]};
          k_d = k_q + LEN_W'(1);
          state_d = k_q == len_q - LEN_W'(1) ? START : LOAD;
        end
      end
      START: begin
        wr_o = 1'b1;
        entrada_o = make_ctrl(10'(len_q));
        cnt_d = '0;
        k_d = '0;
        state_d = POLL;
      end
      POLL: begin
        cnt_d = cnt_q + CW'(1);
        state_d = timed_out ? ABORT : POLL_WAIT;
      end
      POLL_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        state_d = !salida_i[CTRL_SEND] ? UNLOAD : timed_out ? ABORT : POLL;
      end
      ABORT: begin
        wr_o = 1'b1;
        err_o = owner_oh;
        state_d = RELEASE;
      end
      // read k is issued while byte k-1, requested last cycle, is delivered
      UNLOAD: begin
        reg_sel_o = k_q != len_q ? REG_DATA : REG_CTRL;
        addr_d = k_q != len_q ? 32'(k_q) : addr_q;
        rx_valid_o = k_q != '0 ? owner_oh : '0;
        rx_byte_o = k_q != '0 ? salida_i[7:0] : '0;
        k_d = k_q + LEN_W'(1);
        state_d = k_q == len_q ? DONE : UNLOAD;
      end
      DONE: begin
        done_o = owner_oh;
        state_d = RELEASE;
      end
      RELEASE: begin
        rr_d = owner_q == IW'(N_REQ - 1) ? '0 : owner_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      len_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      len_q <= len_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares the SPI master core's register port (control register and data memory) between N_REQ byte-stream requesters.
- Grants one requester at a time, round-robin.
- Per transaction it:
  - loads TX bytes into core data memory,
  - writes the control register with send set,
  - polls until the core clears send,
  - reads RX bytes back to the granted requester.
- Sits between the requester blocks and the SPI core; replaces the single fixed data/control generator.

Parameters:
- N_REQ, 2, number of requesters.
- DEPTH, 16, max bytes per transaction (core data-memory words used, addr 0..DEPTH-1).
- LEN_W, $clog2(DEPTH)+1, width of each length field.
- TIMEOUT, 4096, max poll cycles before abort.

Ports:
- clk_i  in  1  single system clock.
- reset_i  in  1  reset, synchronous, active-low.
- req_i  in  N_REQ  transaction request, level; held until done/err.
- len_i  in  N_REQ*LEN_W  per-requester byte count; sampled at grant.
- tx_byte_i  in  N_REQ*8  per-requester TX byte.
- tx_valid_i  in  N_REQ  TX byte valid.
- tx_ready_o  out  N_REQ  TX byte accepted this cycle (valid&ready).
- rx_byte_o  out  8  RX byte, shared.
- rx_valid_o  out  N_REQ  one-hot RX strobe to owner.
- done_o  out  N_REQ  one-cycle completion pulse.
- err_o  out  N_REQ  one-cycle timeout pulse.
- busy_o  out  1  transaction in progress.
- wr_o  out  1  core register write strobe.
- reg_sel_o  out  1  0=control register, 1=data memory.
- addr_o  out  32  core data-memory address.
- entrada_o  out  32  core write data.
- salida_i  in  32  core read data, valid 1 cycle after a read request.

Behaviour:
- Reset (reset_i==0 at clk_i edge):
  - state=IDLE, rr pointer=0.
  - All outputs 0.
  - Aborts any transaction without touching the core.
- Control word layout (shared package):
  - bit0 send.
  - bit1 all_ones.
  - bit2 all_zeros.
  - [12:4] n_tx_end = len-1.
  - [25:16] n_rx_end = len-1.
  - Arbiter always writes all_ones=all_zeros=0.
- IDLE:
  - Pick the first asserted req_i starting at rr pointer, wrapping.
  - Latch owner and len; len>DEPTH saturates to DEPTH.
  - busy_o=1 next cycle; go LOAD.
  - No request: stay IDLE.
- len==0: go DONE directly; no core access.
- LOAD, for byte index k:
  - tx_ready_o[owner]=1.
  - When tx_valid_i[owner]: wr_o=1, reg_sel_o=1, addr_o=k, entrada_o={24'b0,byte}; k++.
  - Stall without a bus write while valid is low.
  - After k==len-1, go START.
- START (1 cycle): wr_o=1, reg_sel_o=0, entrada_o=control word with send=1; go POLL.
- POLL / POLL_WAIT:
  - POLL issues a read: wr_o=0, reg_sel_o=0.
  - POLL_WAIT samples salida_i.
  - bit0==0: go UNLOAD.
  - bit0==1: back to POLL.
  - A poll counter increments every POLL/POLL_WAIT cycle.
- Timeout: when the counter reaches TIMEOUT:
  - Write control=0 (clear send) for 1 cycle.
  - err_o[owner] pulse; go RELEASE. No RX bytes are delivered.
- UNLOAD (pipelined):
  - Cycle k issues read reg_sel_o=1, addr_o=k.
  - Cycle k+1: rx_byte_o=salida_i[7:0], rx_valid_o[owner]=1.
  - Exactly len strobes, back-to-back, no backpressure.
  - The last strobe is followed by DONE.
- DONE: done_o[owner] 1-cycle pulse; go RELEASE.
- RELEASE (1 cycle):
  - rr pointer = owner+1 mod N_REQ; busy_o=0.
  - Go IDLE; a new grant is possible the following cycle.
- req_i deasserting mid-transaction is ignored; the transaction completes.
- wr_o is never asserted in POLL/POLL_WAIT/UNLOAD.
- addr_o holds its last value when unused.
- Latency, len=L, core busy for P poll rounds: grant to done_o = 1 + L (zero TX stalls) + 1 + 2P + (L+1) + 1 cycles.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum (IDLE, LOAD, START, POLL, POLL_WAIT, UNLOAD, ABORT, DONE, RELEASE),
  - control-word bit positions and the make_ctrl(len) function,
  - REG_CTRL/REG_DATA constants.
- One sub-module: rr_arbiter (N_REQ requests, pointer in, one-hot grant + index out), purely combinational.
- Sequencing stays in spi_txn_arbiter.

Test Plan:
- Requester 0, len=3, bytes A1,B2,C3 valid every cycle; core model clears send after 2 polls, returns RX 11,22,33:
  - data writes addr 0,1,2 = A1,B2,C3.
  - control write 0x0002_0021.
  - rx_valid_o[0] strobes with 11,22,33, then done_o[0].
- req_i=2'b11 continuously, len=1 each: grants alternate 0,1,0,1; never two consecutive grants to the same requester.
- Core never clears send, TIMEOUT=16: err_o[owner] pulse, control write 0, no rx_valid_o, busy_o falls, next requester granted.
- len=0 on requester 1: done_o[1] 2 cycles after grant; wr_o stays 0 throughout.
- len=20 with DEPTH=16: exactly 16 TX pops, n_tx_end=15, 16 RX strobes.
- reset_i low during UNLOAD byte 2: next cycle all outputs 0 and state IDLE; after release, requester 0 is granted first.
